// File: rtl/multi_cycle_sequencer.sv
// Control sequencer for a five-state multi-cycle MIPS-style datapath (IF, ID, EX, MEM, WB).
// Strobes are combinational from the registered state; a retired-instruction counter tracks completions.
module multi_cycle_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             ext_zero,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic [2:0]       state_q, state_d;
    logic             rst_q;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             quiet;

    // Strobes stay low in the reset cycle and the one after it; the first fetch follows.
    assign quiet = rst | rst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            rst_q     <= 1'b1;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_q     <= 1'b0;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        if (quiet) begin
            state_d = S_IF;
        end else begin
            case (state_q)
                S_IF: if (mem_ready) state_d = S_ID;
                S_ID: begin
                    case (opcode)
                        OP_J: begin
                            state_d = S_IF;
                            retire  = 1'b1;
                        end
                        OP_R, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: state_d = S_EX;
                        default: state_d = S_IF;
                    endcase
                end
                S_EX: begin
                    case (opcode)
                        OP_R, OP_ADDI, OP_ORI: state_d = S_WB;
                        OP_LW, OP_SW:          state_d = S_MEM;
                        OP_BEQ: begin
                            state_d = S_IF;
                            retire  = 1'b1;
                        end
                        default: state_d = S_IF;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (opcode == OP_SW) begin
                            state_d = S_IF;
                            retire  = 1'b1;
                        end else if (opcode == OP_LW) begin
                            state_d = S_WB;
                        end else begin
                            state_d = S_IF;
                        end
                    end
                end
                S_WB: begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end
                default: state_d = S_IF;
            endcase
        end
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_src     = 2'd0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        ext_zero   = 1'b0;
        illegal_op = 1'b0;
        if (!quiet) begin
            case (state_q)
                S_IF: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = 2'd1;
                    end
                end
                S_ID: begin
                    alu_src_b = 2'd3;
                    case (opcode)
                        OP_J: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                        end
                        OP_R, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: ;
                        default: illegal_op = 1'b1;
                    endcase
                end
                S_EX: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        OP_R:    alu_op = 2'd2;
                        OP_ADDI: alu_src_b = 2'd2;
                        OP_ORI: begin
                            alu_src_b = 2'd2;
                            alu_op    = 2'd3;
                            ext_zero  = 1'b1;
                        end
                        OP_LW, OP_SW: alu_src_b = 2'd2;
                        OP_BEQ: begin
                            alu_op   = 2'd1;
                            pc_write = zero;
                            pc_src   = 2'd1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == OP_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (opcode == OP_R);
                    mem_to_reg = (opcode == OP_LW);
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: doc/multi_cycle_sequencer.md
MULTI_CYCLE_SEQUENCER -- requirements
Module: multi_cycle_sequencer

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  6  instruction bits [31:26], valid once the instruction register is loaded.
REQ-005 zero  input  1  ALU zero flag, sampled in EX.
REQ-006 mem_ready  input  1  memory completion, one cycle wide, for the current mem_req.
REQ-007 state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-008 mem_req  output  1  memory access request, held until mem_ready.
REQ-009 mem_we  output  1  write qualifier for mem_req.
REQ-010 iord  output  1  memory address select: 0=PC, 1=ALU result.
REQ-011 ir_write, pc_write, reg_write  output  1 each  single-cycle write strobes.
REQ-012 alu_src_a  output  1  0=PC, 1=rs; alu_src_b  output  2  0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2.
REQ-013 alu_op  output  2  0=add, 1=sub, 2=funct-decoded, 3=or.
REQ-014 pc_src  output  2  0=ALU result, 1=branch target, 2=jump target; reg_dst, mem_to_reg, ext_zero  output  1 each.
REQ-015 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-016 retired  output  CNT_W  count of completed instructions.

Function
REQ-017 Opcodes: R_TYPE 000000, J 000010, BEQ 000100, ADDI 001000, ORI 001101, LW 100011, SW 101011; all others are illegal.
REQ-018 Registered 3-bit state; encodings 5-7 unreachable and return to IF on the next cycle with all strobes low.
REQ-019 IF: mem_req=1, iord=0, mem_we=0; hold IF while mem_ready=0.
- On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=0; next state ID.
REQ-020 ID: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
- J: pc_write=1, pc_src=2, retire, next IF.
- Illegal: illegal_op=1, no writes, no retire, next IF.
- Other opcodes: next EX.
REQ-021 EX, R_TYPE: alu_src_a=1, alu_src_b=0, alu_op=2; next WB.
REQ-022 EX, ADDI/ORI: alu_src_a=1, alu_src_b=2, alu_op=0 (ADDI) or 3 (ORI); ext_zero=1 for ORI only; next WB.
REQ-023 EX, LW/SW: alu_src_a=1, alu_src_b=2, alu_op=0; next MEM.
REQ-024 EX, BEQ: alu_src_a=1, alu_src_b=0, alu_op=1; pc_write=zero, pc_src=1; retire; next IF.
REQ-025 MEM: mem_req=1, iord=1, mem_we=1 for SW; hold MEM while mem_ready=0.
- On mem_ready=1: SW retires and goes to IF; LW goes to WB.
REQ-026 WB: reg_write=1.
- R_TYPE: reg_dst=1, mem_to_reg=0. ADDI/ORI: reg_dst=0, mem_to_reg=0. LW: reg_dst=0, mem_to_reg=1.
- Retire; next IF.
REQ-027 Any output not listed for a state is 0; outputs are combinational from state, opcode, zero and mem_ready; state and retired are registered.
REQ-028 Retire means retired increments by 1 at the clock edge that leaves the final state; it wraps modulo 2^CNT_W with no saturation.
REQ-029 mem_ready outside IF/MEM is ignored; mem_req never drops before mem_ready is seen.
REQ-030 opcode is held stable by the external instruction register from ID until return to IF; the sequencer does not latch it.

Reset
REQ-031 With rst=1 at a clock edge: state=IF, retired=0.
- During that cycle and the next, all strobes must be low: mem_req, ir_write, pc_write, reg_write, mem_we, illegal_op.
REQ-032 Reset mid-operation, including during a pending memory wait, abandons the instruction without retiring it; the first fetch starts in the cycle after rst deasserts.

Verification
REQ-033 ADDI, mem_ready on first IF cycle -> states IF,ID,EX,WB,IF; reg_write high only in WB; retired 0->1.
REQ-034 LW with mem_ready delayed 3 cycles in IF and 2 in MEM -> IF held 4 cycles, MEM held 3; mem_req continuous; exactly one ir_write pulse; WB has mem_to_reg=1; retired +1.
REQ-035 BEQ with zero=1, then BEQ with zero=0 -> pc_write=1/pc_src=1 in EX only in the first case; each sequence is 3 states; retired +2.
REQ-036 J -> IF,ID,IF with pc_src=2 in ID; opcode 111111 -> illegal_op pulse in ID and retired unchanged.
REQ-037 rst asserted during a MEM wait of SW -> mem_we never seen with mem_ready; state=IF; retired=0.
REQ-038 Preload retired=2^CNT_W-1 (CNT_W=4), retire one SW -> retired=0.
